// File: rtl/run_seq_pkg.sv
// Shared state encoding and default sizing for the run sequencer.
package run_seq_pkg;

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} run_state_t;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_RUN_W       = 8;
  localparam int DEF_INIT_CYCLES = 2;
  localparam int DEF_MAX_CYCLES  = 2**20;

  // Counter width able to hold 0..n inclusive, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Up-counter with synchronous clear that holds once it reaches max.
module sat_counter
  import run_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK) begin
    if (Reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q < max))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/run_sequencer.sv
// Run controller: holds the CPU in init, releases it, times the run until Halt or timeout.
// Optional min/max run-length statistics are built when RUN_SEQ_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for Go, CPU held in init
//   INIT  | CPU held in init for INIT_CYCLES cycles
//   RUN   | CPU executing, cycles counted
//   DONE  | one-cycle completion pulse, run counted
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RUN_W       = DEF_RUN_W,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Halt,
  output logic             DutStart,
  output logic             Busy,
  output logic             Done,
  output logic             TimedOut,
  output logic [CNT_W-1:0] CycleCt,
  output logic [RUN_W-1:0] RunCt,
  output logic [CNT_W-1:0] MinCt,
  output logic [CNT_W-1:0] MaxCt
);

  localparam int INIT_W = cnt_width(INIT_CYCLES);
  localparam logic [INIT_W-1:0] INIT_MAX  = INIT_W'(INIT_CYCLES);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYC_MAX   = CNT_W'(MAX_CYCLES);

  run_state_t        state;
  logic [INIT_W-1:0] init_q;
  logic              go_accept;
  logic              timeout_hit;

  assign go_accept   = (state == IDLE) && Go;
  assign timeout_hit = (CycleCt == CYC_MAX);

  sat_counter #(.W(INIT_W)) u_init_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .clr   (go_accept),
    .inc   (state == INIT),
    .max   (INIT_MAX),
    .q     (init_q)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .clr   (go_accept),
    .inc   ((state == RUN) && !Halt),
    .max   (CYC_MAX),
    .q     (CycleCt)
  );

  // Outputs are updated together with the state so they always match it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      DutStart <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      TimedOut <= 1'b0;
      RunCt    <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Go) begin
            state    <= INIT;
            Busy     <= 1'b1;
            TimedOut <= 1'b0;
          end
        end
        INIT: begin
          if (init_q == INIT_LAST) begin
            state    <= RUN;
            DutStart <= 1'b0;
          end
        end
        RUN: begin
          // Halt takes priority over a coincident timeout.
          if (Halt || timeout_hit) begin
            state    <= DONE;
            Done     <= 1'b1;
            TimedOut <= !Halt;
            RunCt    <= RunCt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          DutStart <= 1'b1;
          Busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          DutStart <= 1'b1;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef RUN_SEQ_STATS_EN
  // Only halted runs contribute; the count is final on the Halt cycle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      MinCt <= '1;
      MaxCt <= '0;
    end else if ((state == RUN) && Halt) begin
      if (CycleCt < MinCt) MinCt <= CycleCt;
      if (CycleCt > MaxCt) MaxCt <= CycleCt;
    end
  end
`else
  assign MinCt = '1;
  assign MaxCt = '0;
`endif

endmodule
